mips_single_cpu: RTL and testbench

Five-stage pipelined MIPS-subset CPU (IF/ID/EX/MEM/WB) with on-chip byte-addressed instruction and data memories and a 32×32 register file. It is the top of the CPU design; the bench only drives clock and reset and preloads memories and registers hierarchically. Data hazards are resolved by software (NOP insertion). Branches and jumps resolve in ID with one architectural delay slot.

---
 rtl/mips_pkg.sv | 62 ++++++
 rtl/mips_mem.sv | 34 +++
 rtl/mips_reg_file.sv | 31 +++
 rtl/mips_single_cpu.sv | 167 ++++++++++++++++
 tb/tb_mips_single_cpu.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the five-stage MIPS-subset pipeline: encodings, ALU ops and
// pipeline-register layouts.
package mips_pkg;

   localparam logic [5:0] OpRtype = 6'd0;
   localparam logic [5:0] OpJ     = 6'd2;
   localparam logic [5:0] OpBeq   = 6'd4;
   localparam logic [5:0] OpAddiu = 6'd9;
   localparam logic [5:0] OpLw    = 6'd35;
   localparam logic [5:0] OpSw    = 6'd43;

   localparam logic [5:0] FnSrl   = 6'd2;
   localparam logic [5:0] FnMfhi  = 6'd16;
   localparam logic [5:0] FnMflo  = 6'd18;
   localparam logic [5:0] FnMultu = 6'd25;
   localparam logic [5:0] FnAdd   = 6'd32;
   localparam logic [5:0] FnSub   = 6'd34;
   localparam logic [5:0] FnAnd   = 6'd36;
   localparam logic [5:0] FnOr    = 6'd37;

   typedef enum logic [2:0] {
      AluAdd, AluSub, AluAnd, AluOr, AluSrl, AluHi, AluLo
   } alu_op_e;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
   } if_id_t;

   typedef struct packed {
      alu_op_e     alu_op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  shamt;
      logic [31:0] st_data;
      logic [4:0]  dst;
      logic        reg_we;
      logic        mem_we;
      logic        mem_re;
      logic        hilo_we;
   } id_ex_t;

   typedef struct packed {
      logic [31:0] result;
      logic [31:0] st_data;
      logic [4:0]  dst;
      logic        reg_we;
      logic        mem_we;
      logic        mem_re;
   } ex_mem_t;

   typedef struct packed {
      logic [31:0] wd;
      logic [4:0]  dst;
      logic        reg_we;
   } mem_wb_t;

   function automatic logic [31:0] sext16(input logic [15:0] imm);
      return {{16{imm[15]}}, imm};
   endfunction

endpackage

// File: rtl/mips_mem.sv
// Byte-addressed memory: combinational little-endian word read, word write on the rising edge.
// Contents have no reset so preloaded data survives a CPU reset.
module mips_mem #(
   parameter int unsigned BYTES = 1024
) (
   input  logic        i_clk,
   input  logic        i_we,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata
);
   localparam int unsigned AW = $clog2(BYTES);

   logic [7:0]    mem_array [BYTES];
   logic [AW-3:0] w_word;
   logic          w_unused_addr;

   // Low address bits are forced to zero; bits above the array size wrap.
   assign w_word        = i_addr[AW-1:2];
   assign w_unused_addr = ^{i_addr[31:AW], i_addr[1:0]};

   assign o_rdata = {mem_array[{w_word, 2'd3}], mem_array[{w_word, 2'd2}],
                     mem_array[{w_word, 2'd1}], mem_array[{w_word, 2'd0}]};

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem_array[{w_word, 2'd0}] <= i_wdata[7:0];
         mem_array[{w_word, 2'd1}] <= i_wdata[15:8];
         mem_array[{w_word, 2'd2}] <= i_wdata[23:16];
         mem_array[{w_word, 2'd3}] <= i_wdata[31:24];
      end
   end

endmodule

// File: rtl/mips_reg_file.sv
// 32x32 register file: two combinational read ports with write-through, one write port,
// register 0 hardwired to zero.
module mips_reg_file (
   input  logic        i_clk,
   input  logic [4:0]  i_ra1,
   input  logic [4:0]  i_ra2,
   output logic [31:0] o_rd1,
   output logic [31:0] o_rd2,
   input  logic        i_we,
   input  logic [4:0]  i_wa,
   input  logic [31:0] i_wd
);
   logic [31:0] file_array [32];

   always_ff @(posedge i_clk) begin
      if (i_we && (i_wa != 5'd0)) begin
         file_array[i_wa] <= i_wd;
      end
   end

   // Write-through lets ID see a WB result in the same cycle.
   always_comb begin
      o_rd1 = file_array[i_ra1];
      o_rd2 = file_array[i_ra2];
      if (i_we && (i_wa == i_ra1)) o_rd1 = i_wd;
      if (i_we && (i_wa == i_ra2)) o_rd2 = i_wd;
      if (i_ra1 == 5'd0) o_rd1 = '0;
      if (i_ra2 == 5'd0) o_rd2 = '0;
   end

endmodule

// File: rtl/mips_single_cpu.sv
// Five-stage MIPS-subset CPU, branches resolved in ID with one delay slot, no forwarding.
// Define MIPS_MULTU_EN to build the HI/LO registers and MULTU/MFHI/MFLO.
module mips_single_cpu
   import mips_pkg::*;
#(
   parameter int unsigned IMEM_BYTES = 1024,
   parameter int unsigned DMEM_BYTES = 1024
) (
   input  logic clk,
   input  logic rst
);
   logic [31:0] pc;
   logic [31:0] w_pc_next;
   logic [31:0] w_if_instr;
   if_id_t      r_ifid;
   id_ex_t      r_idex, w_idex;
   ex_mem_t     r_exmem, w_exmem;
   mem_wb_t     r_memwb, w_memwb;

   logic [31:0] ID_instr;
   logic [5:0]  ID_opcode;
   logic [5:0]  ID_funct;
   logic [31:0] rfile_wd;
   logic [31:0] w_rs_val, w_rt_val, w_imm, w_dm_rdata;

   assign ID_instr  = r_ifid.instr;
   assign ID_opcode = ID_instr[31:26];
   assign ID_funct  = ID_instr[5:0];
   assign w_imm     = sext16(ID_instr[15:0]);
   assign rfile_wd  = r_memwb.wd;

   mips_mem #(.BYTES(IMEM_BYTES)) InstrMem (
      .i_clk   (clk),
      .i_we    (1'b0),
      .i_addr  (pc),
      .i_wdata (32'd0),
      .o_rdata (w_if_instr)
   );

   mips_reg_file RegFile (
      .i_clk (clk),
      .i_ra1 (ID_instr[25:21]),
      .i_ra2 (ID_instr[20:16]),
      .o_rd1 (w_rs_val),
      .o_rd2 (w_rt_val),
      .i_we  (r_memwb.reg_we),
      .i_wa  (r_memwb.dst),
      .i_wd  (rfile_wd)
   );

   mips_mem #(.BYTES(DMEM_BYTES)) DatMem (
      .i_clk   (clk),
      .i_we    (r_exmem.mem_we),
      .i_addr  (r_exmem.result),
      .i_wdata (r_exmem.st_data),
      .o_rdata (w_dm_rdata)
   );

   // ID: decode, register read, branch/jump resolution
   always_comb begin
      w_idex         = '0;
      w_idex.a       = w_rs_val;
      w_idex.b       = w_rt_val;
      w_idex.shamt   = ID_instr[10:6];
      w_idex.st_data = w_rt_val;
      w_idex.dst     = ID_instr[15:11];
      w_pc_next      = pc + 32'd4;
      case (ID_opcode)
         OpRtype: begin
            case (ID_funct)
               FnAdd: begin w_idex.alu_op = AluAdd; w_idex.reg_we = 1'b1; end
               FnSub: begin w_idex.alu_op = AluSub; w_idex.reg_we = 1'b1; end
               FnAnd: begin w_idex.alu_op = AluAnd; w_idex.reg_we = 1'b1; end
               FnOr:  begin w_idex.alu_op = AluOr;  w_idex.reg_we = 1'b1; end
               FnSrl: begin w_idex.alu_op = AluSrl; w_idex.reg_we = 1'b1; end
`ifdef MIPS_MULTU_EN
               FnMultu: w_idex.hilo_we = 1'b1;
               FnMfhi: begin w_idex.alu_op = AluHi; w_idex.reg_we = 1'b1; end
               FnMflo: begin w_idex.alu_op = AluLo; w_idex.reg_we = 1'b1; end
`endif
               default: ;
            endcase
         end
         OpAddiu, OpLw: begin
            w_idex.b      = w_imm;
            w_idex.dst    = ID_instr[20:16];
            w_idex.reg_we = 1'b1;
            w_idex.mem_re = (ID_opcode == OpLw);
         end
         OpSw: begin
            w_idex.b      = w_imm;
            w_idex.mem_we = 1'b1;
         end
         OpBeq: begin
            if (w_rs_val == w_rt_val) w_pc_next = r_ifid.pc4 + {w_imm[29:0], 2'b00};
         end
         OpJ: w_pc_next = {r_ifid.pc4[31:28], ID_instr[25:0], 2'b00};
         default: ;
      endcase
   end

`ifdef MIPS_MULTU_EN
   logic [31:0] r_hi, r_lo;
   logic [63:0] w_prod;

   assign w_prod = 64'(r_idex.a) * 64'(r_idex.b);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (r_idex.hilo_we) begin
         {r_hi, r_lo} <= w_prod;
      end
   end
`else
   logic w_unused_hilo;
   assign w_unused_hilo = r_idex.hilo_we;
`endif

   // EX
   always_comb begin
      w_exmem         = '0;
      w_exmem.st_data = r_idex.st_data;
      w_exmem.dst     = r_idex.dst;
      w_exmem.reg_we  = r_idex.reg_we;
      w_exmem.mem_we  = r_idex.mem_we;
      w_exmem.mem_re  = r_idex.mem_re;
      case (r_idex.alu_op)
         AluAdd:  w_exmem.result = r_idex.a + r_idex.b;
         AluSub:  w_exmem.result = r_idex.a - r_idex.b;
         AluAnd:  w_exmem.result = r_idex.a & r_idex.b;
         AluOr:   w_exmem.result = r_idex.a | r_idex.b;
         AluSrl:  w_exmem.result = r_idex.b >> r_idex.shamt;
`ifdef MIPS_MULTU_EN
         AluHi:   w_exmem.result = r_hi;
         AluLo:   w_exmem.result = r_lo;
`endif
         default: w_exmem.result = '0;
      endcase
   end

   // MEM
   always_comb begin
      w_memwb        = '0;
      w_memwb.wd     = r_exmem.mem_re ? w_dm_rdata : r_exmem.result;
      w_memwb.dst    = r_exmem.dst;
      w_memwb.reg_we = r_exmem.reg_we;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc      <= '0;
         r_ifid  <= '0;
         r_idex  <= '0;
         r_exmem <= '0;
         r_memwb <= '0;
      end else begin
         pc      <= w_pc_next;
         r_ifid  <= '{instr: w_if_instr, pc4: pc + 32'd4};
         r_idex  <= w_idex;
         r_exmem <= w_exmem;
         r_memwb <= w_memwb;
      end
   end

endmodule

// File: tb/tb_mips_single_cpu.sv
// Bench for mips_single_cpu: directed programs plus random NOP-spaced programs, all checked
// against an instruction-level model with delay-slot semantics.
module tb_mips_single_cpu;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   mips_single_cpu #(.IMEM_BYTES(1024), .DMEM_BYTES(1024)) dut (
      .clk (clk),
      .rst (rst)
   );

   int          n_checks = 0;
   int          n_errs   = 0;
   logic [31:0] prog   [256];
   logic [31:0] m_reg  [32];
   logic [7:0]  m_dmem [1024];
   logic [31:0] m_hi, m_lo;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, int fn);
      return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
   endfunction

   function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
      return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic logic [31:0] enc_j(int op, int addr);
      return {6'(op), 26'(addr)};
   endfunction

   task automatic clear_prog();
      for (int i = 0; i < 256; i++) prog[i] = '0;
   endtask

   // Preload: copy program, model registers and model data memory into the DUT.
   task automatic reset_load();
      rst = 1'b1;
      m_reg[0] = '0;
      for (int i = 0; i < 32; i++) dut.RegFile.file_array[i] = m_reg[i];
      for (int i = 0; i < 1024; i++) dut.DatMem.mem_array[i] = m_dmem[i];
      for (int w = 0; w < 256; w++)
         for (int b = 0; b < 4; b++) dut.InstrMem.mem_array[4*w+b] = prog[w][8*b +: 8];
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] r, input logic [31:0] v);
      if (r != 5'd0) m_reg[r] = v;
   endtask

   // Sequential ISA interpreter: pc/npc pair models the single delay slot.
   task automatic model_run(input int steps);
      logic [31:0] pc, npc, nxt, ins, a, b, imm;
      int          addr;
      logic [4:0]  rs, rt, rd;
      pc = 0; npc = 4; m_hi = 0; m_lo = 0;
      repeat (steps) begin
         ins = prog[pc[9:2]];
         rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
         a = m_reg[rs]; b = m_reg[rt];
         imm = {{16{ins[15]}}, ins[15:0]};
         nxt = npc + 4;
         addr = int'((a + imm) & 32'h3FC);
         case (ins[31:26])
            6'd0: case (ins[5:0])
               6'd32: wr(rd, a + b);
               6'd34: wr(rd, a - b);
               6'd36: wr(rd, a & b);
               6'd37: wr(rd, a | b);
               6'd2:  wr(rd, b >> ins[10:6]);
`ifdef MIPS_MULTU_EN
               6'd25: {m_hi, m_lo} = 64'(a) * 64'(b);
               6'd16: wr(rd, m_hi);
               6'd18: wr(rd, m_lo);
`endif
               default: ;
            endcase
            6'd9:  wr(rt, a + imm);
            6'd35: wr(rt, {m_dmem[addr+3], m_dmem[addr+2], m_dmem[addr+1], m_dmem[addr]});
            6'd43: begin
               m_dmem[addr] = b[7:0];    m_dmem[addr+1] = b[15:8];
               m_dmem[addr+2] = b[23:16]; m_dmem[addr+3] = b[31:24];
            end
            6'd4:  if (a == b) nxt = pc + 4 + (imm << 2);
            6'd2:  nxt = {pc[31:28] + ((pc[27:0] > 28'hFFFFFFB) ? 4'd1 : 4'd0), ins[25:0], 2'b00};
            default: ;
         endcase
         pc = npc;
         npc = nxt;
      end
   endtask

   task automatic compare_all(input string tag);
      for (int r = 1; r < 32; r++)
         check($sformatf("%s reg%0d", tag, r), dut.RegFile.file_array[r], m_reg[r]);
      for (int w = 0; w < 256; w++)
         check($sformatf("%s dmem%0d", tag, 4*w),
               {dut.DatMem.mem_array[4*w+3], dut.DatMem.mem_array[4*w+2],
                dut.DatMem.mem_array[4*w+1], dut.DatMem.mem_array[4*w]},
               {m_dmem[4*w+3], m_dmem[4*w+2], m_dmem[4*w+1], m_dmem[4*w]});
   endtask

   // One random instruction for group g; branch/jump targets are later group starts.
   function automatic logic [31:0] gen_instr(int g);
      int rs = $urandom_range(0, 31);
      int rt = $urandom_range(0, 31);
      int rd = $urandom_range(0, 31);
      int tgt = 5 * (g + 1 + $urandom_range(0, 2));
      case ($urandom_range(0, 12))
         0:  return enc_r(rs, rt, rd, 0, 32);
         1:  return enc_r(rs, rt, rd, 0, 34);
         2:  return enc_r(rs, rt, rd, 0, 36);
         3:  return enc_r(rs, rt, rd, 0, 37);
         4:  return enc_r(0, rt, rd, $urandom_range(0, 31), 2);
         5:  return enc_i(9, rs, rt, $urandom_range(0, 65535));
         6:  return enc_i(35, 0, rt, $urandom_range(0, 1023));
         7:  return enc_i(43, 0, rt, $urandom_range(0, 1023));
         8:  return enc_i(4, rs, ($urandom_range(0, 1) != 0) ? rs : rt, tgt - (5 * g + 1));
         9:  return enc_j(2, tgt);
         10: return enc_r(rs, rt, 0, 0, 25);
         11: return enc_r(0, 0, rd, 0, ($urandom_range(0, 1) != 0) ? 16 : 18);
         default: return ($urandom_range(0, 1) != 0) ?
                         {6'($urandom_range(5, 8)), 26'($urandom)} : enc_r(rs, rt, rd, 0, 33);
      endcase
   endfunction

   initial begin
      for (int i = 0; i < 32; i++) m_reg[i] = $urandom;
      for (int i = 0; i < 1024; i++) m_dmem[i] = 8'($urandom);
      m_reg[1] = 32'd5;
      m_reg[2] = 32'd7;

      // Reset: pipeline empty, preloaded registers retained
      clear_prog();
      reset_load();
      check("rst pc", dut.pc, 32'd0);
      check("rst id_instr", dut.ID_instr, 32'd0);
      check("rst wd", dut.rfile_wd, 32'd0);
      rst = 1'b0;
      step(10);
      check("rst r1", dut.RegFile.file_array[1], 32'd5);
      check("rst r2", dut.RegFile.file_array[2], 32'd7);

      // ALU
      clear_prog();
      prog[0] = enc_r(1, 2, 3, 0, 32);
      prog[5] = enc_r(2, 1, 4, 0, 34);
      reset_load();
      rst = 1'b0;
      step(1);
      check("alu pc", dut.pc, 32'd4);
      check("alu id_opcode", 32'(dut.ID_opcode), 32'd0);
      check("alu id_funct", 32'(dut.ID_funct), 32'd32);
      step(3);
      check("alu wb_wd", dut.rfile_wd, 32'd12);
      step(20);
      check("alu r3", dut.RegFile.file_array[3], 32'd12);
      check("alu r4", dut.RegFile.file_array[4], 32'd2);
      model_run(24);
      compare_all("alu");

      // Memory
      clear_prog();
      prog[0]  = enc_i(9, 0, 5, 8);
      prog[5]  = enc_i(43, 5, 2, 0);
      prog[10] = enc_i(35, 5, 6, 0);
      reset_load();
      rst = 1'b0;
      step(30);
      check("mem b8", 32'(dut.DatMem.mem_array[8]), 32'h07);
      check("mem b9", 32'(dut.DatMem.mem_array[9]), 32'h00);
      check("mem b10", 32'(dut.DatMem.mem_array[10]), 32'h00);
      check("mem b11", 32'(dut.DatMem.mem_array[11]), 32'h00);
      check("mem r6", dut.RegFile.file_array[6], 32'd7);
      model_run(30);
      compare_all("mem");

      // Branch with delay slot
      m_reg[7] = 32'd0; m_reg[10] = 32'h1234; m_reg[11] = 32'd0;
      clear_prog();
      prog[0] = enc_i(4, 1, 1, 2);
      prog[1] = enc_i(9, 0, 7, 1);
      prog[2] = enc_i(9, 0, 10, 99);
      prog[3] = enc_i(9, 0, 11, 55);
      reset_load();
      rst = 1'b0;
      #1 check("beq pc0", dut.pc, 32'd0);
      step(1);
      check("beq pc1", dut.pc, 32'd4);
      step(1);
      check("beq pc2", dut.pc, 32'd12);
      step(20);
      check("beq slot r7", dut.RegFile.file_array[7], 32'd1);
      check("beq skip r10", dut.RegFile.file_array[10], 32'h1234);
      check("beq tgt r11", dut.RegFile.file_array[11], 32'd55);
      model_run(22);
      compare_all("beq");

      // Jump
      m_reg[12] = 32'd0;
      clear_prog();
      prog[0]  = enc_j(2, 16);
      prog[2]  = enc_i(9, 0, 12, 7);
      prog[16] = enc_i(9, 0, 12, 3);
      reset_load();
      rst = 1'b0;
      #1 check("j pc0", dut.pc, 32'd0);
      step(1);
      check("j pc1", dut.pc, 32'd4);
      step(1);
      check("j pc2", dut.pc, 32'h40);
      step(20);
      check("j r12", dut.RegFile.file_array[12], 32'd3);
      model_run(22);
      compare_all("j");

      // Multiply
      m_reg[1] = 32'hFFFF_FFFF; m_reg[2] = 32'd2;
      m_reg[8] = 32'hDEAD_0000; m_reg[9] = 32'hDEAD_0000;
      clear_prog();
      prog[0] = enc_r(1, 2, 0, 0, 25);
      prog[1] = enc_r(0, 0, 8, 0, 16);
      prog[2] = enc_r(0, 0, 9, 0, 18);
      reset_load();
      rst = 1'b0;
      step(20);
`ifdef MIPS_MULTU_EN
      check("mul r8", dut.RegFile.file_array[8], 32'd1);
      check("mul r9", dut.RegFile.file_array[9], 32'hFFFF_FFFE);
`else
      check("mul r8", dut.RegFile.file_array[8], 32'hDEAD_0000);
      check("mul r9", dut.RegFile.file_array[9], 32'hDEAD_0000);
`endif
      model_run(20);
      compare_all("mul");

      // Reset mid-program: in-flight instructions are dropped
      m_reg[14] = 32'h77; m_reg[15] = 32'h88;
      clear_prog();
      prog[0] = enc_i(9, 0, 14, 5);
      prog[2] = enc_i(9, 0, 15, 9);
      reset_load();
      rst = 1'b0;
      step(3);
      rst = 1'b1;
      #1;
      check("mid pc", dut.pc, 32'd0);
      check("mid id_instr", dut.ID_instr, 32'd0);
      check("mid wd", dut.rfile_wd, 32'd0);
      step(3);
      check("mid r14", dut.RegFile.file_array[14], 32'h77);
      check("mid r15", dut.RegFile.file_array[15], 32'h88);
      @(negedge clk);
      rst = 1'b0;
      step(20);
      check("mid r14 rerun", dut.RegFile.file_array[14], 32'd5);
      model_run(20);
      compare_all("mid");

      // Random NOP-spaced programs
      for (int t = 0; t < 4; t++) begin
         for (int i = 1; i < 32; i++) m_reg[i] = $urandom;
         for (int i = 0; i < 1024; i++) m_dmem[i] = 8'($urandom);
         clear_prog();
         for (int g = 0; g < 12; g++) prog[5*g] = gen_instr(g);
         reset_load();
         rst = 1'b0;
         step(100);
         model_run(100);
         compare_all($sformatf("rand%0d", t));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end

endmodule
